// File: rtl/magic_device_arbiter_if.sv
// rtl/magic_device_arbiter_if.sv - requester and device-port bundle for the magic device arbiter
interface magic_device_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*12-1:0] req_select;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [63:0]        resp_data;
  logic [11:0]        dev_read_select;
  logic               dev_read_ready;
  logic               dev_read_valid;
  logic [63:0]        dev_read_data;

  modport master (
    input  req_valid, req_select, dev_read_valid, dev_read_data,
    output req_ready, resp_valid, resp_data, dev_read_select, dev_read_ready
  );

  modport slave (
    output req_valid, req_select, dev_read_valid, dev_read_data,
    input  req_ready, resp_valid, resp_data, dev_read_select, dev_read_ready
  );
endinterface

// File: rtl/magic_device_arbiter.sv
// rtl/magic_device_arbiter.sv - round-robin sharing of one randomizer device read port
module magic_device_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  magic_device_arbiter_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     txn_count
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant_q, grant_d;
  logic [11:0]      sel_q, sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
  logic [63:0]      resp_data_q, resp_data_d;
  logic [CNT_W-1:0] txn_q, txn_d;

  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] idx;
  logic             found;
  logic [11:0]      sel_pick;
  logic             any_req;
  logic [NREQ-1:0]  grant_oh;

  assign any_req  = |bus.req_valid;
  assign grant_oh = NREQ'(1) << grant_q;

  // Scan starts at rr_ptr and wraps, so the last-served requester goes to the back.
  always_comb begin
    pick  = rr_ptr_q;
    found = 1'b0;
    idx   = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == LAST) ? '0 : idx + PTR_W'(1);
    end
  end

  always_comb begin
    sel_pick = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PTR_W'(i) == pick) sel_pick = bus.req_select[i*12 +: 12];
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    txn_d        = txn_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          sel_d   = sel_pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dev_read_valid) begin
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          resp_data_d  = bus.dev_read_data;
          resp_valid_d = grant_oh;
          state_d      = RESP;
        end
      end
      RESP: begin
        resp_valid_d = '0;
        rr_ptr_d     = (grant_q == LAST) ? '0 : grant_q + PTR_W'(1);
        txn_d        = txn_q + CNT_W'(1);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      sel_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      txn_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      txn_q        <= txn_d;
    end
  end

  // Ready is held low during reset so nothing looks accepted while the block is cleared.
  assign bus.req_ready       = (reset && state_q == IDLE && any_req) ? NREQ'(1) << pick : '0;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_data       = resp_data_q;
  assign bus.dev_read_select = sel_q;
  assign bus.dev_read_ready  = (state_q == ISSUE);
  assign busy                = (state_q != IDLE);
  assign txn_count           = txn_q;
endmodule

// File: tb/tb_magic_device_arbiter.sv
// tb/tb_magic_device_arbiter.sv - bench for magic_device_arbiter at LATENCY 1 and 4
module tb_magic_device_arbiter;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  magic_device_arbiter_if #(.NREQ(4)) bus0 ();
  magic_device_arbiter_if #(.NREQ(4)) bus1 ();

  logic        busy0, busy1;
  logic [3:0]  txn0;
  logic [31:0] txn1;

  magic_device_arbiter #(.NREQ(4), .LATENCY(1), .CNT_W(4)) u_dut0 (
    .clock(clock), .reset(reset), .bus(bus0), .busy(busy0), .txn_count(txn0)
  );
  magic_device_arbiter #(.NREQ(4), .LATENCY(4), .CNT_W(32)) u_dut1 (
    .clock(clock), .reset(reset), .bus(bus1), .busy(busy1), .txn_count(txn1)
  );

  logic [3:0]  d_valid    [2];
  logic [47:0] d_sel      [2];
  logic        d_dev_valid[2];
  logic [63:0] d_dev_data [2];

  assign bus0.req_valid      = d_valid[0];
  assign bus0.req_select     = d_sel[0];
  assign bus0.dev_read_valid = d_dev_valid[0];
  assign bus0.dev_read_data  = d_dev_data[0];
  assign bus1.req_valid      = d_valid[1];
  assign bus1.req_select     = d_sel[1];
  assign bus1.dev_read_valid = d_dev_valid[1];
  assign bus1.dev_read_data  = d_dev_data[1];

  logic [3:0]  o_ready[2], o_resp[2];
  logic [63:0] o_data [2];
  logic [11:0] o_dsel [2];
  logic        o_dready[2], o_busy[2];
  logic [31:0] o_txn  [2];

  always_comb begin
    o_ready[0] = bus0.req_ready;  o_ready[1] = bus1.req_ready;
    o_resp[0]  = bus0.resp_valid; o_resp[1]  = bus1.resp_valid;
    o_data[0]  = bus0.resp_data;  o_data[1]  = bus1.resp_data;
    o_dsel[0]  = bus0.dev_read_select; o_dsel[1] = bus1.dev_read_select;
    o_dready[0] = bus0.dev_read_ready; o_dready[1] = bus1.dev_read_ready;
    o_busy[0]  = busy0;           o_busy[1]  = busy1;
    o_txn[0]   = {28'd0, txn0};   o_txn[1]   = txn1;
  end

  int          total = 0;
  int          bad = 0;
  int          ptr[2];
  logic [31:0] count[2];
  int          lat[2];
  logic [31:0] cmask[2];
  int          hits[2][4];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] mask, input int p);
    for (int k = 0; k < 4; k++) begin
      if (mask[(p + k) % 4]) return (p + k) % 4;
    end
    return 0;
  endfunction

  task automatic run_txn(input int inst, input logic [3:0] mask, input int stall,
                         input logic [47:0] sel, input bit fixed, input logic [63:0] fdata,
                         output logic [3:0] got);
    int          g;
    logic [3:0]  oh;
    logic [11:0] exp_sel;
    logic [63:0] exp_data, d;
    g        = rr_pick(mask, ptr[inst]);
    oh       = 4'(1 << g);
    exp_sel  = sel[g*12 +: 12];
    exp_data = '0;
    got      = '0;
    d_sel[inst]       = sel;
    d_valid[inst]     = mask;
    d_dev_valid[inst] = (stall == 0);
    #1;
    chk("req_ready_idle", {60'd0, o_ready[inst]}, {60'd0, oh});
    tick();
    d_sel[inst] = 48'({$urandom, $urandom});
    #1;
    chk("req_ready_busy", {60'd0, o_ready[inst]}, 64'd0);
    chk("busy_issue", {63'd0, o_busy[inst]}, 64'd1);
    chk("dev_ready_issue", {63'd0, o_dready[inst]}, 64'd1);
    chk("dev_sel_issue", {52'd0, o_dsel[inst]}, {52'd0, exp_sel});
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_ready", {63'd0, o_dready[inst]}, 64'd1);
      chk("stall_sel", {52'd0, o_dsel[inst]}, {52'd0, exp_sel});
    end
    d_dev_valid[inst] = 1'b1;
    d_dev_data[inst]  = {$urandom, $urandom};
    tick();
    d_dev_valid[inst] = 1'($urandom);
    chk("dev_ready_wait", {63'd0, o_dready[inst]}, 64'd0);
    chk("dev_sel_wait", {52'd0, o_dsel[inst]}, {52'd0, exp_sel});
    for (int e = 1; e <= lat[inst]; e++) begin
      d = fixed ? fdata : {32'hDA7A_0000 | 32'(e), $urandom};
      d_dev_data[inst] = d;
      if (e == lat[inst]) exp_data = d;
      tick();
      for (int i = 0; i < 4; i++) if (o_resp[inst][i]) hits[inst][i]++;
      if (e < lat[inst]) begin
        chk("no_early_resp", {60'd0, o_resp[inst]}, 64'd0);
      end else begin
        got = o_resp[inst];
        chk("resp_valid", {60'd0, o_resp[inst]}, {60'd0, oh});
        chk("resp_data", o_data[inst], exp_data);
      end
    end
    d_dev_valid[inst] = 1'b0;
    d_dev_data[inst]  = {$urandom, $urandom};
    tick();
    count[inst] = (count[inst] + 32'd1) & cmask[inst];
    ptr[inst]   = (g + 1) % 4;
    chk("resp_pulse_end", {60'd0, o_resp[inst]}, 64'd0);
    chk("busy_done", {63'd0, o_busy[inst]}, 64'd0);
    chk("resp_data_hold", o_data[inst], exp_data);
    chk("txn_count", {32'd0, o_txn[inst]}, {32'd0, count[inst]});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int n = 0; n < 2; n++) begin
      ptr[n]   = 0;
      count[n] = '0;
    end
  endtask

  initial begin
    logic [3:0] got;
    logic [3:0] m;
    lat[0] = 1;          lat[1] = 4;
    cmask[0] = 32'hF;    cmask[1] = 32'hFFFF_FFFF;
    for (int n = 0; n < 2; n++) begin
      d_valid[n] = 4'hF;
      d_sel[n] = '0;
      d_dev_valid[n] = 1'b0;
      d_dev_data[n] = '0;
      ptr[n] = 0;
      count[n] = '0;
      for (int i = 0; i < 4; i++) hits[n][i] = 0;
    end
    reset = 1'b0;
    tick();
    tick();
    for (int n = 0; n < 2; n++) begin
      chk("rst_busy", {63'd0, o_busy[n]}, 64'd0);
      chk("rst_resp_valid", {60'd0, o_resp[n]}, 64'd0);
      chk("rst_resp_data", o_data[n], 64'd0);
      chk("rst_dev_ready", {63'd0, o_dready[n]}, 64'd0);
      chk("rst_dev_sel", {52'd0, o_dsel[n]}, 64'd0);
      chk("rst_txn", {32'd0, o_txn[n]}, 64'd0);
      chk("rst_req_ready", {60'd0, o_ready[n]}, 64'd0);
      d_valid[n] = 4'h0;
    end
    reset = 1'b1;
    tick();
    #1;
    chk("idle_no_req_ready", {60'd0, o_ready[0]}, 64'd0);
    tick();
    chk("idle_stays", {63'd0, o_busy[0]}, 64'd0);

    run_txn(0, 4'b0001, 0, 48'h123, 1'b1, 64'hDEADBEEF_00000001, got);
    chk("single_txn_count", {32'd0, o_txn[0]}, 64'd1);
    d_valid[0] = 4'h0;

    do_reset();
    for (int i = 0; i < 4; i++) hits[0][i] = 0;
    for (int k = 0; k < 8; k++) begin
      run_txn(0, 4'b1111, 0, 48'({$urandom, $urandom}), 1'b0, 64'd0, got);
      chk("fair_order", {60'd0, got}, {60'd0, 4'(1 << (k % 4))});
    end
    for (int i = 0; i < 4; i++) chk("fair_hits", 64'(hits[0][i]), 64'd2);
    d_valid[0] = 4'h0;

    run_txn(1, 4'b0100, 5, 48'({$urandom, $urandom}), 1'b0, 64'd0, got);
    chk("stall_grant", {60'd0, got}, 64'h4);
    d_valid[1] = 4'h0;
    run_txn(1, 4'b0011, 0, 48'({$urandom, $urandom}), 1'b0, 64'd0, got);
    chk("lat4_grant", {60'd0, got}, 64'h1);
    for (int k = 0; k < 6; k++) begin
      m = 4'($urandom_range(1, 15));
      run_txn(1, m, int'($urandom_range(0, 3)), 48'({$urandom, $urandom}), 1'b0, 64'd0, got);
    end
    d_valid[1] = 4'h0;

    do_reset();
    d_valid[1] = 4'b1000;
    d_dev_valid[1] = 1'b1;
    tick();
    tick();
    d_valid[1] = 4'h0;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, o_busy[1]}, 64'd0);
    chk("midrst_resp", {60'd0, o_resp[1]}, 64'd0);
    chk("midrst_dev_ready", {63'd0, o_dready[1]}, 64'd0);
    chk("midrst_txn", {32'd0, o_txn[1]}, 64'd0);
    tick();
    reset = 1'b1;
    ptr[1] = 0;
    count[1] = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("postrst_resp", {60'd0, o_resp[1]}, 64'd0);
      chk("postrst_txn", {32'd0, o_txn[1]}, 64'd0);
    end
    d_dev_valid[1] = 1'b0;

    do_reset();
    for (int k = 0; k < 16; k++) begin
      m = 4'($urandom_range(1, 15));
      run_txn(0, m, int'($urandom_range(0, 2)), 48'({$urandom, $urandom}), 1'b0, 64'd0, got);
      if (k == 14) chk("wrap_max", {32'd0, o_txn[0]}, 64'hF);
    end
    chk("wrap_zero", {32'd0, o_txn[0]}, 64'd0);
    d_valid[0] = 4'h0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
